// File: rtl/powerup_pool.sv
// rtl/powerup_pool.sv - pool of bouncing power-up sprites with catch detection and boost timer
//
// Purpose:
//   Holds N_SLOTS power-up sprites. Spawn requests take the lowest free slot, live
//   slots move once per frame tick with edge bounce (or exit past the bottom), the
//   pixel path reports which sprite covers the current pixel, and an overlap with an
//   opaque player pixel catches that sprite and (re)starts the boost timer.
//
// Ports:
//   CLK, RESET_N              clock, asynchronous active-low reset
//   frame_tick, pause         per-frame strobe; pause freezes motion and boost timer
//   spawn_req                 spawn request, one request per cycle held high
//   spawn_x/y, step_x/y       spawn top-left position and signed per-frame motion
//   spawn_ack, spawn_full     registered result of the previous cycle's request
//   DrawX/DrawY               current pixel
//   rom_color                 sprite ROM colour at (idx_x, idx_y)
//   player_active             player pixel opaque at DrawX/DrawY
//   idx_x/idx_y               pixel offset inside the hit sprite
//   pix_active, Color         opaque power-up pixel flag and ROM colour passthrough
//   slot_valid                live-slot mask
//   boost                     boost effect active
//   catch_count               saturating catch counter
module powerup_pool #(
   parameter int          N_SLOTS      = 4,
   parameter int          SPR_W        = 35,
   parameter int          SPR_H        = 35,
   parameter int          X_MAX        = 639,
   parameter int          Y_MAX        = 479,
   parameter int          BOOST_FRAMES = 600,
   parameter logic [11:0] XPARENT      = 12'h111,
   parameter bit          BOTTOM_EXIT  = 1'b1
) (
   input  logic               CLK,
   input  logic               RESET_N,
   input  logic               frame_tick,
   input  logic               pause,
   input  logic               spawn_req,
   input  logic [9:0]         spawn_x,
   input  logic [9:0]         spawn_y,
   input  logic [9:0]         step_x,
   input  logic [9:0]         step_y,
   output logic               spawn_ack,
   output logic               spawn_full,
   input  logic [9:0]         DrawX,
   input  logic [9:0]         DrawY,
   input  logic [11:0]        rom_color,
   input  logic               player_active,
   output logic [7:0]         idx_x,
   output logic [7:0]         idx_y,
   output logic               pix_active,
   output logic [11:0]        Color,
   output logic [N_SLOTS-1:0] slot_valid,
   output logic               boost,
   output logic [7:0]         catch_count
);

   localparam int          SEL_W  = (N_SLOTS > 1) ? $clog2(N_SLOTS) : 1;
   localparam logic [11:0] W12    = 12'(SPR_W);
   localparam logic [11:0] H12    = 12'(SPR_H);
   localparam logic [11:0] XMAX12 = 12'(X_MAX);
   localparam logic [11:0] YMAX12 = 12'(Y_MAX);

   // One axis of motion: returns {new_pos, new_vel}. Positions are widened to 12 bits
   // so pos+vel+size never wraps before the edge comparisons.
   function automatic logic [19:0] move_axis(input logic [9:0] pos, input logic [9:0] vel,
                                             input logic [11:0] size, input logic [11:0] lim);
      logic [11:0] mag;
      logic [11:0] far;
      mag = {2'b00, (vel[9] ? 10'(-vel) : vel)};
      far = {2'b00, pos} + {2'b00, vel} + size;
      if (vel != 10'd0 && !vel[9] && far > lim) return {10'(lim - size), 10'(-vel)};
      if (vel[9] && {2'b00, pos} < mag) return {10'd0, 10'(-vel)};
      return {pos + vel, vel};
   endfunction

   // Far-edge (right/bottom) crossing on the next step.
   function automatic logic far_hit(input logic [9:0] pos, input logic [9:0] vel,
                                    input logic [11:0] size, input logic [11:0] lim);
      logic [11:0] far;
      far = {2'b00, pos} + {2'b00, vel} + size;
      return (vel != 10'd0) && !vel[9] && (far > lim);
   endfunction

   logic [N_SLOTS-1:0] valid_q, valid_d;
   logic [9:0]         x_q  [N_SLOTS];
   logic [9:0]         x_d  [N_SLOTS];
   logic [9:0]         y_q  [N_SLOTS];
   logic [9:0]         y_d  [N_SLOTS];
   logic [9:0]         vx_q [N_SLOTS];
   logic [9:0]         vx_d [N_SLOTS];
   logic [9:0]         vy_q [N_SLOTS];
   logic [9:0]         vy_d [N_SLOTS];
   logic [15:0]        timer_q, timer_d;
   logic [7:0]         count_q, count_d;
   logic               ack_q, ack_d;
   logic               full_q, full_d;
   logic               boost_q, boost_d;

   logic [19:0]        mx    [N_SLOTS];
   logic [19:0]        my    [N_SLOTS];
   logic [N_SLOTS-1:0] exit_y;
   logic [N_SLOTS-1:0] hit_vec;
   logic               hit;
   logic [SEL_W-1:0]   hit_sel;
   logic               free_found;
   logic [SEL_W-1:0]   free_sel;
   logic               catch_go;
   logic               move;
   logic [9:0]         off_x, off_y;

   // Pixel path: per-slot bounding-box test, lowest live index wins.
   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         hit_vec[i] = valid_q[i]
                    && ({2'b00, DrawX} >= {2'b00, x_q[i]})
                    && ({2'b00, DrawX} <  {2'b00, x_q[i]} + W12)
                    && ({2'b00, DrawY} >= {2'b00, y_q[i]})
                    && ({2'b00, DrawY} <  {2'b00, y_q[i]} + H12);
      end
   end

   always_comb begin
      hit     = 1'b0;
      hit_sel = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (hit_vec[i]) begin
            hit     = 1'b1;
            hit_sel = SEL_W'(i);
         end
      end
      off_x      = DrawX - x_q[hit_sel];
      off_y      = DrawY - y_q[hit_sel];
      idx_x      = hit ? off_x[7:0] : 8'd0;
      idx_y      = hit ? off_y[7:0] : 8'd0;
      pix_active = hit && (rom_color != XPARENT);
      catch_go   = pix_active && player_active;
   end

   assign Color = rom_color;

   // Free slot search uses the registered mask, so a slot caught this cycle is
   // only reusable once its valid bit has actually dropped.
   always_comb begin
      free_found = 1'b0;
      free_sel   = '0;
      for (int i = N_SLOTS - 1; i >= 0; i--) begin
         if (!valid_q[i]) begin
            free_found = 1'b1;
            free_sel   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_SLOTS; i++) begin
         mx[i]     = move_axis(x_q[i], vx_q[i], W12, XMAX12);
         my[i]     = move_axis(y_q[i], vy_q[i], H12, YMAX12);
         exit_y[i] = far_hit(y_q[i], vy_q[i], H12, YMAX12);
      end
   end

   assign move = frame_tick && !pause;

   always_comb begin
      valid_d = valid_q;
      for (int i = 0; i < N_SLOTS; i++) begin
         x_d[i]  = x_q[i];
         y_d[i]  = y_q[i];
         vx_d[i] = vx_q[i];
         vy_d[i] = vy_q[i];
         if (catch_go && hit_sel == SEL_W'(i)) begin
            // Catch beats motion: the slot leaves without moving.
            valid_d[i] = 1'b0;
         end else if (valid_q[i] && move) begin
            {x_d[i], vx_d[i]} = mx[i];
            if (BOTTOM_EXIT && exit_y[i]) valid_d[i] = 1'b0;
            else {y_d[i], vy_d[i]} = my[i];
         end
         if (spawn_req && free_found && free_sel == SEL_W'(i)) begin
            valid_d[i] = 1'b1;
            x_d[i]     = spawn_x;
            y_d[i]     = spawn_y;
            vx_d[i]    = step_x;
            vy_d[i]    = step_y;
         end
      end
   end

   always_comb begin
      ack_d   = spawn_req && free_found;
      full_d  = spawn_req && !free_found;
      timer_d = timer_q;
      count_d = count_q;
      if (catch_go) begin
         // Reload rather than add: a re-catch extends, never stacks.
         timer_d = 16'(BOOST_FRAMES);
         if (count_q != 8'hFF) count_d = count_q + 8'd1;
      end else if (move && timer_q != 16'd0) begin
         timer_d = timer_q - 16'd1;
      end
      boost_d = (timer_d != 16'd0);
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         valid_q <= '0;
         for (int i = 0; i < N_SLOTS; i++) begin
            x_q[i]  <= '0;
            y_q[i]  <= '0;
            vx_q[i] <= '0;
            vy_q[i] <= '0;
         end
         timer_q <= '0;
         count_q <= '0;
         ack_q   <= 1'b0;
         full_q  <= 1'b0;
         boost_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
         for (int i = 0; i < N_SLOTS; i++) begin
            x_q[i]  <= x_d[i];
            y_q[i]  <= y_d[i];
            vx_q[i] <= vx_d[i];
            vy_q[i] <= vy_d[i];
         end
         timer_q <= timer_d;
         count_q <= count_d;
         ack_q   <= ack_d;
         full_q  <= full_d;
         boost_q <= boost_d;
      end
   end

   assign spawn_ack   = ack_q;
   assign spawn_full  = full_q;
   assign slot_valid  = valid_q;
   assign boost       = boost_q;
   assign catch_count = count_q;

endmodule
